// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
// Word-organised RAM behind a request/ready handshake with misalignment flags.
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen,
    input  logic [3:0]  memwrite,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        stall,
    output logic        adel,
    output logic        ades
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          we_q;
    logic [31:0]         wd_q;
    logic                mis_q;
    logic [31:0]         mem [2**ADDR_W];

    logic mis_in;
    logic do_access;
    logic unused_addr;

    assign mis_in      = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    assign do_access   = (state == BUSY) && (cnt == 3'd0) && !mis_q;
    assign stall       = (state == IDLE && memen) || (state == BUSY);
    assign unused_addr = ^addr[31:ADDR_W+2];

    // RAM is deliberately left out of reset; a reset during BUSY leaves do_access low.
    always_ff @(posedge clk) begin
        if (do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (we_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            idx_q    <= '0;
            we_q     <= 4'd0;
            wd_q     <= 32'd0;
            mis_q    <= 1'b0;
            readdata <= 32'd0;
            ready    <= 1'b0;
            adel     <= 1'b0;
            ades     <= 1'b0;
        end else begin
            ready <= 1'b0;
            adel  <= 1'b0;
            ades  <= 1'b0;
            case (state)
                // RESP accepts at its closing edge so back-to-back accesses take WAIT+2 cycles.
                IDLE, RESP: begin
                    if (memen) begin
                        state <= BUSY;
                        cnt   <= 3'(WAIT);
                        idx_q <= addr[ADDR_W+1:2];
                        we_q  <= memwrite;
                        wd_q  <= writedata;
                        mis_q <= mis_in;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= RESP;
                        ready <= 1'b1;
                        if (mis_q) begin
                            adel <= (we_q == 4'd0);
                            ades <= (we_q != 4'd0);
                        end else begin
                            readdata <= mem[idx_q];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// Cycle-level occupancy model plus directed literal checks on two instances.
module tb_dmem_responder;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memen;
    logic [3:0]  memwrite;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready, stall, adel, ades;

    logic        z_memen;
    logic [3:0]  z_memwrite;
    logic [1:0]  z_size;
    logic [31:0] z_addr;
    logic [31:0] z_writedata;
    logic [31:0] z_readdata;
    logic        z_ready, z_stall, z_adel, z_ades;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT(WAIT)) dut (
        .clk(clk), .rst(rst_n), .memen(memen), .memwrite(memwrite), .size(size),
        .addr(addr), .writedata(writedata), .readdata(readdata), .ready(ready),
        .stall(stall), .adel(adel), .ades(ades)
    );

    dmem_responder #(.ADDR_W(10), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst_n), .memen(z_memen), .memwrite(z_memwrite), .size(z_size),
        .addr(z_addr), .writedata(z_writedata), .readdata(z_readdata), .ready(z_ready),
        .stall(z_stall), .adel(z_adel), .ades(z_ades)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: an accepted request occupies the port for WAIT+1 cycles, then one response cycle.
    int          cyc = 0;
    bit          pending = 0;
    int          done_c = 0;
    int          p_idx;
    logic [3:0]  p_we;
    logic [31:0] p_wd;
    bit          p_mis;
    logic        e_ready = 0, e_adel = 0, e_ades = 0;
    logic [31:0] e_rd = 0;
    bit          rd_known = 1;
    logic [31:0] mm [int];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  = 0;
            e_ready  = 0;
            e_adel   = 0;
            e_ades   = 0;
            e_rd     = 0;
            rd_known = 1;
        end else begin
            cyc++;
            e_ready = 0;
            e_adel  = 0;
            e_ades  = 0;
            if (pending) begin
                if (cyc == done_c) begin
                    pending = 0;
                    e_ready = 1;
                    if (p_mis) begin
                        if (p_we == 4'd0) e_adel = 1; else e_ades = 1;
                    end else begin
                        logic [31:0] w;
                        if (mm.exists(p_idx)) begin
                            e_rd = mm[p_idx];
                            rd_known = 1;
                        end else begin
                            rd_known = 0;
                        end
                        if (mm.exists(p_idx) || p_we == 4'hF) begin
                            w = mm.exists(p_idx) ? mm[p_idx] : 32'd0;
                            for (int i = 0; i < 4; i++)
                                if (p_we[i]) w[8*i +: 8] = p_wd[8*i +: 8];
                            mm[p_idx] = w;
                        end
                    end
                end
            end else if (memen) begin
                pending = 1;
                done_c  = cyc + WAIT + 1;
                p_idx   = int'(addr[11:2]);
                p_we    = memwrite;
                p_wd    = writedata;
                p_mis   = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("stall", stall, pending || (!e_ready && memen));
            check("ready", ready, e_ready);
            check("adel", adel, e_adel);
            check("ades", ades, e_ades);
            if (rd_known) check("readdata", readdata, e_rd);
        end
    end

    task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] we,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output logic el, output logic es);
        @(posedge clk); #1;
        memen = 1; addr = a; size = sz; memwrite = we; writedata = wd;
        lat = -1; rd = 32'd0; el = 0; es = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n; rd = readdata; el = adel; es = ades;
                break;
            end
        end
        memen = 0;
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL access_timeout: got no ready expected ready at addr %h", a);
        end
    endtask

    task automatic z_access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        z_memen = 1; z_addr = a; z_size = 2'b10; z_memwrite = we; z_writedata = wd;
        lat = -1; rd = 32'd0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (z_ready) begin
                lat = n; rd = z_readdata;
                break;
            end
        end
        z_memen = 0;
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL z_access_timeout: got no ready expected ready at addr %h", a);
        end
    endtask

    logic [31:0] rd;
    int          lat;
    logic        el, es;
    int          hits[$];

    initial begin
        rst_n = 0;
        memen = 0; memwrite = 0; size = 0; addr = 0; writedata = 0;
        z_memen = 0; z_memwrite = 0; z_size = 0; z_addr = 0; z_writedata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_ready", ready, 1'b0);
        check("reset_adel_ades", {adel, ades}, 2'b00);
        check("reset_stall", stall, 1'b0);
        rst_n  = 1;
        chk_en = 1;

        access(32'h10, 2'b10, 4'hF, 32'h0, rd, lat, el, es);
        access(32'h00, 2'b10, 4'hF, 32'h0, rd, lat, el, es);
        access(32'h20, 2'b10, 4'hF, 32'h1111_2222, rd, lat, el, es);

        access(32'h10, 2'b10, 4'hF, 32'hDEAD_BEEF, rd, lat, el, es);
        check("store_latency", lat, 3);
        check("store_prewrite", rd, 32'h0);
        access(32'h10, 2'b10, 4'h0, 32'h0, rd, lat, el, es);
        check("load_latency", lat, 3);
        check("load_word", rd, 32'hDEAD_BEEF);

        access(32'h12, 2'b00, 4'b0100, 32'h00AA_0000, rd, lat, el, es);
        access(32'h10, 2'b10, 4'h0, 32'h0, rd, lat, el, es);
        check("byte_merge", rd, 32'hDEAA_BEEF);

        access(32'h06, 2'b10, 4'h0, 32'h0, rd, lat, el, es);
        check("adel_flag", {el, es}, 2'b10);
        check("adel_rd_held", rd, 32'hDEAA_BEEF);
        access(32'h03, 2'b01, 4'b0011, 32'h0000_FFFF, rd, lat, el, es);
        check("ades_flag", {el, es}, 2'b01);
        access(32'h00, 2'b10, 4'h0, 32'h0, rd, lat, el, es);
        check("ades_no_write", rd, 32'h0);

        @(posedge clk); #1;
        memen = 1; addr = 32'h10; size = 2'b10; memwrite = 4'h0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                hits.push_back(n);
                if (hits.size() == 3) begin
                    memen = 0;
                    break;
                end
            end
        end
        memen = 0;
        check("b2b_count", hits.size(), 3);
        if (hits.size() == 3) begin
            check("b2b_first", hits[0], 3);
            check("b2b_second", hits[1], 7);
            check("b2b_third", hits[2], 11);
        end

        @(posedge clk); #1;
        memen = 1; addr = 32'h20; size = 2'b10; memwrite = 4'hF; writedata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        memen = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("abort_readdata", readdata, 32'h0);
        check("abort_ready_stall", {ready, stall}, 2'b00);
        check("abort_adel_ades", {adel, ades}, 2'b00);
        @(negedge clk); #2;
        rst_n = 1;
        access(32'h20, 2'b10, 4'h0, 32'h0, rd, lat, el, es);
        check("abort_no_write", rd, 32'h1111_2222);

        z_access(32'h10, 4'hF, 32'h1234_5678, rd, lat);
        check("w0_store_latency", lat, 1);
        z_access(32'h0000_1010, 4'h0, 32'h0, rd, lat);
        check("w0_alias_load", rd, 32'h1234_5678);
        check("w0_load_latency", lat, 1);

        @(posedge clk); #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
